// File: rtl/keypad_entry.sv
// Keypad digit entry for the M:ST:SO countdown timer. Decodes one-hot keys,
// shifts accepted digits into the entry register and issues the timer load strobe.
module keypad_entry #(
    parameter int DIGIT_W = 4,
    parameter int KEYS    = 10
) (
    input  logic               clock,
    input  logic               clrn,
    input  logic [KEYS-1:0]    keypad,
    input  logic               startn,
    input  logic               cleark,
    input  logic               entry_en,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] mins,
    output logic               loadn,
    output logic               pressed,
    output logic               err
);

    // state   | meaning
    // IDLE    | waiting for a valid key or a start edge
    // CAPTURE | latched digit evaluated, shift or reject this cycle
    // RELEASE | waiting for all keys to be released
    typedef enum logic [1:0] {IDLE, CAPTURE, RELEASE} state_t;

    localparam int CNT_W = $clog2(KEYS + 1);

    state_t             state, state_nxt;
    logic [DIGIT_W-1:0] digit;
    logic [DIGIT_W-1:0] key_val;
    logic [CNT_W-1:0]   key_cnt;
    logic               key_valid;
    logic               startn_q;
    logic               start_evt;
    logic               nonzero;
    logic               shift_en;

    always_comb begin
        key_val = '0;
        key_cnt = '0;
        for (int k = 0; k < KEYS; k++) begin
            if (keypad[k]) begin
                key_val = DIGIT_W'(k);
                key_cnt = key_cnt + CNT_W'(1);
            end
        end
        key_valid = (key_cnt == CNT_W'(1));
    end

    assign start_evt = startn_q && !startn && entry_en && (state == IDLE);
    assign nonzero   = |{mins, sec_tens, sec_ones};

    always_ff @(posedge clock) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!entry_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // a start edge wins over a simultaneous key, but the key must still be released
                    if (start_evt && key_valid) state_nxt = RELEASE;
                    else if (key_valid)         state_nxt = CAPTURE;
                end
                CAPTURE: state_nxt = RELEASE;
                RELEASE: if (keypad == '0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // pulses are gated by clrn so an aborted capture produces no visible pulse
    always_comb begin
        pressed  = 1'b0;
        err      = 1'b0;
        shift_en = 1'b0;
        if ((state == CAPTURE) && entry_en && clrn) begin
            if (sec_ones > DIGIT_W'(5)) begin
                err = 1'b1;
            end else begin
                pressed  = 1'b1;
                shift_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!clrn) begin
            sec_ones <= '0;
            sec_tens <= '0;
            mins     <= '0;
            digit    <= '0;
            loadn    <= 1'b1;
            startn_q <= 1'b1;
        end else begin
            startn_q <= startn;
            loadn    <= !(start_evt && nonzero && !cleark);
            if ((state == IDLE) && entry_en && key_valid) digit <= key_val;
            // the timer samples the digits during the loadn-low cycle, so clear one cycle later
            if (cleark || !loadn) begin
                sec_ones <= '0;
                sec_tens <= '0;
                mins     <= '0;
            end else if (shift_en) begin
                mins     <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= digit;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry.
module tb_keypad_entry;

    logic       clock = 1'b0;
    logic       clrn;
    logic [9:0] keypad;
    logic       startn;
    logic       cleark;
    logic       entry_en;
    logic [3:0] sec_ones, sec_tens, mins;
    logic       loadn, pressed, err;

    int n_checks = 0;
    int n_fail   = 0;

    keypad_entry #(.DIGIT_W(4), .KEYS(10)) dut (
        .clock    (clock),
        .clrn     (clrn),
        .keypad   (keypad),
        .startn   (startn),
        .cleark   (cleark),
        .entry_en (entry_en),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .loadn    (loadn),
        .pressed  (pressed),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // hold key k for n cycles, then release for 2 cycles; count pulse cycles
    task automatic hold_key(input int k, input int n, output int np, output int ne);
        np = 0;
        ne = 0;
        keypad = '0;
        keypad[k] = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            np += int'(pressed);
            ne += int'(err);
        end
        keypad = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            np += int'(pressed);
            ne += int'(err);
        end
    endtask

    task automatic clear_entry();
        cleark = 1'b1;
        step();
        cleark = 1'b0;
        step();
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        keypad = '0;
        startn = 1'b1;
        cleark = 1'b0;
        entry_en = 1'b1;
        step();
        step();
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_digits got %h want 000", {mins, sec_tens, sec_ones});
        end
        n_checks++;
        if ({loadn, pressed, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 100", {loadn, pressed, err});
        end
        clrn = 1'b1;
        step();
    endtask

    task automatic test_entry();
        int np, ne, tp, te;
        keypad = 10'b0000000010;
        step();
        n_checks++;
        if (pressed !== 1'b1 || sec_ones !== 4'd0) begin
            n_fail++;
            $display("FAIL latency_pulse got pressed=%b so=%0d want pressed=1 so=0", pressed, sec_ones);
        end
        step();
        n_checks++;
        if (pressed !== 1'b0 || sec_ones !== 4'd1) begin
            n_fail++;
            $display("FAIL latency_update got pressed=%b so=%0d want pressed=0 so=1", pressed, sec_ones);
        end
        tp = 1;
        te = 0;
        step();
        keypad = '0;
        step();
        step();
        hold_key(3, 3, np, ne);
        tp += np; te += ne;
        hold_key(0, 3, np, ne);
        tp += np; te += ne;
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h130) begin
            n_fail++;
            $display("FAIL entry_130 got %h want 130", {mins, sec_tens, sec_ones});
        end
        n_checks++;
        if (tp !== 3 || te !== 0) begin
            n_fail++;
            $display("FAIL entry_pulses got pressed=%0d err=%0d want 3 0", tp, te);
        end
    endtask

    task automatic test_reject();
        int np, ne;
        clear_entry();
        hold_key(0, 2, np, ne);
        hold_key(0, 2, np, ne);
        hold_key(7, 2, np, ne);
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h007) begin
            n_fail++;
            $display("FAIL reject_setup got %h want 007", {mins, sec_tens, sec_ones});
        end
        hold_key(2, 3, np, ne);
        n_checks++;
        if (ne !== 1 || np !== 0) begin
            n_fail++;
            $display("FAIL reject_pulses got err=%0d pressed=%0d want 1 0", ne, np);
        end
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h007) begin
            n_fail++;
            $display("FAIL reject_hold got %h want 007", {mins, sec_tens, sec_ones});
        end
    endtask

    task automatic test_multi_key();
        int np, ne;
        np = 0;
        ne = 0;
        keypad = 10'b0000000110;
        for (int i = 0; i < 5; i++) begin
            step();
            np += int'(pressed);
            ne += int'(err);
        end
        keypad = '0;
        step();
        n_checks++;
        if (np !== 0 || ne !== 0 || {mins, sec_tens, sec_ones} !== 12'h007) begin
            n_fail++;
            $display("FAIL multi_key got p=%0d e=%0d digits=%h want 0 0 007", np, ne, {mins, sec_tens, sec_ones});
        end
        // a following single key must be taken at once if the FSM stayed idle
        keypad = 10'b0000000001;
        step();
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_key_idle got err=%b want 1", err);
        end
        keypad = '0;
        step();
        step();
    endtask

    task automatic test_start();
        int np, ne, nlow;
        clear_entry();
        hold_key(1, 2, np, ne);
        hold_key(3, 2, np, ne);
        hold_key(0, 2, np, ne);
        startn = 1'b0;
        step();
        n_checks++;
        if (loadn !== 1'b0 || {mins, sec_tens, sec_ones} !== 12'h130) begin
            n_fail++;
            $display("FAIL start_load got loadn=%b digits=%h want 0 130", loadn, {mins, sec_tens, sec_ones});
        end
        step();
        n_checks++;
        if (loadn !== 1'b1 || {mins, sec_tens, sec_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL start_clear got loadn=%b digits=%h want 1 000", loadn, {mins, sec_tens, sec_ones});
        end
        nlow = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nlow += int'(!loadn);
        end
        n_checks++;
        if (nlow !== 0) begin
            n_fail++;
            $display("FAIL start_single got extra loadn cycles=%0d want 0", nlow);
        end
        startn = 1'b1;
        step();
        startn = 1'b0;
        nlow = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nlow += int'(!loadn);
        end
        n_checks++;
        if (nlow !== 0) begin
            n_fail++;
            $display("FAIL start_zero got loadn cycles=%0d want 0", nlow);
        end
        startn = 1'b1;
        step();
    endtask

    task automatic test_held_key();
        int np, ne, nlow;
        hold_key(5, 20, np, ne);
        n_checks++;
        if (np !== 1 || ne !== 0 || sec_ones !== 4'd5) begin
            n_fail++;
            $display("FAIL held_key got p=%0d e=%0d so=%0d want 1 0 5", np, ne, sec_ones);
        end
        entry_en = 1'b0;
        hold_key(4, 3, np, ne);
        startn = 1'b0;
        nlow = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            nlow += int'(!loadn);
        end
        startn = 1'b1;
        n_checks++;
        if (np !== 0 || nlow !== 0 || {mins, sec_tens, sec_ones} !== 12'h005) begin
            n_fail++;
            $display("FAIL entry_disabled got p=%0d loadn_low=%0d digits=%h want 0 0 005", np, nlow, {mins, sec_tens, sec_ones});
        end
        entry_en = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int np;
        clear_entry();
        hold_key(1, 2, np, np);
        startn = 1'b0;
        keypad = 10'b1000000000;
        step();
        n_checks++;
        if (loadn !== 1'b0) begin
            n_fail++;
            $display("FAIL start_vs_key_load got loadn=%b want 0", loadn);
        end
        np = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            np += int'(pressed);
        end
        keypad = '0;
        step();
        step();
        startn = 1'b1;
        step();
        n_checks++;
        if (np !== 0 || {mins, sec_tens, sec_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL start_vs_key_ignore got p=%0d digits=%h want 0 000", np, {mins, sec_tens, sec_ones});
        end
    endtask

    task automatic test_clear_reset();
        int np, ne;
        clear_entry();
        hold_key(1, 2, np, ne);
        hold_key(2, 2, np, ne);
        hold_key(3, 2, np, ne);
        hold_key(4, 2, np, ne);
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h234) begin
            n_fail++;
            $display("FAIL shift_off got %h want 234", {mins, sec_tens, sec_ones});
        end
        cleark = 1'b1;
        step();
        cleark = 1'b0;
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL cleark got %h want 000", {mins, sec_tens, sec_ones});
        end
        hold_key(8, 2, np, ne);
        keypad = 10'b0010000000;
        step();
        clrn = 1'b0;
        keypad = '0;
        #1;
        n_checks++;
        if (pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pulse got pressed=%b want 0", pressed);
        end
        step();
        clrn = 1'b1;
        n_checks++;
        if ({mins, sec_tens, sec_ones} !== 12'h000 || {loadn, pressed, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_reset got digits=%h flags=%b want 000 100", {mins, sec_tens, sec_ones}, {loadn, pressed, err});
        end
        np = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            np += int'(pressed) + int'(err);
        end
        n_checks++;
        if (np !== 0 || {mins, sec_tens, sec_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_after got pulses=%0d digits=%h want 0 000", np, {mins, sec_tens, sec_ones});
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_reject();
        test_multi_key();
        test_start();
        test_held_key();
        test_back_to_back();
        test_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
